// File: rtl/shift_deser.sv
// Serial-to-parallel receiver: assembles WIDTH-bit words from strobed serial bits, MSB- or LSB-first.
// Latency: word visible in the cycle after its final strobe (one strobe later with SHIFT_DESER_PARITY_EN).
// Backpressure: one-entry holding register with valid/ready; a word completing into a full register is dropped and sets overrun.
// Optional feature macro: SHIFT_DESER_PARITY_EN (trailing even-parity bit per word, sticky parity_err output).
module shift_deser #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             dir,
    input  logic             clear,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             overrun
`ifdef SHIFT_DESER_PARITY_EN
    ,
    output logic             parity_err
`endif
);

`ifdef SHIFT_DESER_PARITY_EN
    // The parity bit occupies one extra counter slot after the last data bit.
    localparam int LAST = WIDTH;
`else
    localparam int LAST = WIDTH - 1;
`endif
    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] r_sr;
    logic [CW-1:0]    r_cnt;
    logic             r_dir_q;
    logic [WIDTH-1:0] r_out;
    logic             r_out_valid;
    logic             r_overrun;

    logic             w_first;
    logic             w_dir;
    logic [WIDTH-1:0] w_shift;
    logic             w_accept;
    logic             w_at_last;
    logic             w_done;
    logic             w_free;
    logic             w_load;
    logic             w_drop;
    logic [WIDTH-1:0] w_word;
    logic             w_shift_en;

    // The first bit of a word uses the live dir pin, since dir_q is only captured on that same edge.
    assign w_first    = (r_cnt == '0);
    assign w_dir      = w_first ? dir : r_dir_q;
    assign w_shift    = w_dir ? {sin, r_sr[WIDTH-1:1]} : {r_sr[WIDTH-2:0], sin};

    // clear wins over a coincident strobe, so that bit never counts.
    assign w_accept   = sin_valid && !clear;
    assign w_at_last  = (r_cnt == CW'(LAST));
    assign w_done     = w_accept && w_at_last;

    // The holding register can take a new word if empty or being popped this cycle.
    assign w_free     = !r_out_valid || out_ready;
    assign w_load     = w_done && w_free;
    assign w_drop     = w_done && !w_free;

`ifdef SHIFT_DESER_PARITY_EN
    // Data is already complete in sr when the parity bit arrives; the parity bit itself is never shifted in.
    logic r_parity_err;
    logic w_par_bad;
    assign w_word     = r_sr;
    assign w_shift_en = w_accept && !w_at_last;
    assign w_par_bad  = ^{r_sr, sin};
`else
    // The word includes the bit arriving on the completing edge.
    assign w_word     = w_shift;
    assign w_shift_en = w_accept;
`endif

    // Shift register and bit counter; clear aborts the partial word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sr  <= '0;
            r_cnt <= '0;
        end else if (clear) begin
            r_sr  <= '0;
            r_cnt <= '0;
        end else if (w_accept) begin
            if (w_shift_en)
                r_sr <= w_shift;
            r_cnt <= w_at_last ? '0 : r_cnt + CW'(1);
        end
    end

    // Latch bit order on the first bit so mid-word dir changes are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_dir_q <= 1'b0;
        else if (w_accept && w_first)
            r_dir_q <= dir;
    end

    // Holding register: load on completion when free, otherwise drain on pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else if (w_load) begin
            r_out       <= w_word;
            r_out_valid <= 1'b1;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Sticky overrun: a completed word found the holding register occupied.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_overrun <= 1'b0;
        else if (clear)
            r_overrun <= 1'b0;
        else if (w_drop)
            r_overrun <= 1'b1;
    end

`ifdef SHIFT_DESER_PARITY_EN
    // Sticky parity error; the word is delivered regardless of the check.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_parity_err <= 1'b0;
        else if (clear)
            r_parity_err <= 1'b0;
        else if (w_done && w_par_bad)
            r_parity_err <= 1'b1;
    end

    assign parity_err = r_parity_err;
`endif

    assign out       = r_out;
    assign out_valid = r_out_valid;
    assign overrun   = r_overrun;
    assign busy      = !w_first;

endmodule

// File: tb/tb_shift_deser.sv
// Directed bench for shift_deser with a queue scoreboard of expected words.
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: out_ready driven explicitly per step to exercise pop, hold and overrun cases.
module tb_shift_deser;

    logic       clk = 1'b0;
    logic       rst;
    logic       sin;
    logic       sin_valid;
    logic       dir;
    logic       clear;
    logic [7:0] out;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       overrun;
`ifdef SHIFT_DESER_PARITY_EN
    logic       parity_err;
    localparam int NS = 9;
`else
    localparam int NS = 8;
`endif

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_w;

    always #5 clk = ~clk;

    shift_deser #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .sin       (sin),
        .sin_valid (sin_valid),
        .dir       (dir),
        .clear     (clear),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .overrun   (overrun)
`ifdef SHIFT_DESER_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bit i of the serial stream for word w; index 8 is the even-parity bit.
    function automatic logic stream_bit(input logic [7:0] w, input logic ord, input int i);
        if (i >= 8)
            return ^w;
        return ord ? w[i] : w[7-i];
    endfunction

    // Strobes stream bits [from, to) on consecutive cycles; dir is left as the caller set it.
    task automatic send_range(input logic [7:0] w, input logic ord, input int from, input int to);
        for (int i = from; i < to; i++) begin
            sin       = stream_bit(w, ord, i);
            sin_valid = 1'b1;
            tick();
        end
        sin_valid = 1'b0;
    endtask

    // Compares the held word with the scoreboard head, then pops it.
    task automatic check_pop(input string tag);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: DUT word 0x%0h present but scoreboard empty", tag, out);
        end else begin
            check({tag, "_valid"}, out_valid, 1);
            check({tag, "_data"}, out, exp_q.pop_front());
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            check({tag, "_drained"}, out_valid, 0);
        end
    endtask

    initial begin
        rst = 1'b1; sin = 1'b0; sin_valid = 1'b0; dir = 1'b0; clear = 1'b0; out_ready = 1'b0;
        #1;
        check("rst_out", out, 0);
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
`ifdef SHIFT_DESER_PARITY_EN
        check("rst_parity", parity_err, 0);
`endif
        tick();
        rst = 1'b0;
        tick();

        // MSB-first A5 with exact latency on the final strobe.
        dir = 1'b0;
        exp_q.push_back(8'hA5);
        send_range(8'hA5, 1'b0, 0, 1);
        check("msb_busy_mid", busy, 1);
        send_range(8'hA5, 1'b0, 1, NS - 1);
        check("msb_valid_early", out_valid, 0);
        send_range(8'hA5, 1'b0, NS - 1, NS);
        check("msb_busy_done", busy, 0);
        check_pop("msb_a5");

        // LSB-first: same bits give A5, then 1,1,0.. gives 03.
        dir = 1'b1;
        exp_q.push_back(8'hA5);
        send_range(8'hA5, 1'b1, 0, NS);
        check_pop("lsb_a5");
        exp_q.push_back(8'h03);
        send_range(8'h03, 1'b1, 0, NS);
        check_pop("lsb_03");

        // Overrun: 3C held, FF dropped, clear resets flag but keeps the word.
        dir = 1'b0;
        exp_q.push_back(8'h3C);
        send_range(8'h3C, 1'b0, 0, NS);
        send_range(8'hFF, 1'b0, 0, NS);
        check("ovr_flag", overrun, 1);
        check("ovr_out_kept", out, 8'h3C);
        check("ovr_busy", busy, 0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("ovr_cleared", overrun, 0);
        check_pop("ovr_word");

        // Pop and completion on the same edge.
        exp_q.push_back(8'h5A);
        send_range(8'h5A, 1'b0, 0, NS);
        send_range(8'hC3, 1'b0, 0, NS - 1);
        check("sim_valid_before", out_valid, 1);
        check("sim_old_word", out, exp_q.pop_front());
        out_ready = 1'b1;
        send_range(8'hC3, 1'b0, NS - 1, NS);
        out_ready = 1'b0;
        exp_q.push_back(8'hC3);
        check("sim_valid_kept", out_valid, 1);
        check("sim_no_overrun", overrun, 0);
        check_pop("sim_new_word");

        // Abort: clear beats a coincident strobe; then mid-word dir toggle is ignored.
        dir = 1'b0;
        send_range(8'hFF, 1'b0, 0, 3);
        check("abort_busy_before", busy, 1);
        clear = 1'b1; sin = 1'b1; sin_valid = 1'b1;
        tick();
        clear = 1'b0; sin_valid = 1'b0;
        check("abort_busy_after", busy, 0);
        check("abort_no_word", out_valid, 0);
        exp_q.push_back(8'h96);
        send_range(8'h96, 1'b0, 0, 4);
        dir = 1'b1;
        send_range(8'h96, 1'b0, 4, NS);
        dir = 1'b0;
        check_pop("dirlatch_96");

        // Reset mid-word with a word held; next strobe restarts at bit 0.
        send_range(8'h11, 1'b0, 0, NS);
        send_range(8'h55, 1'b0, 0, 5);
        rst = 1'b1;
        #1;
        check("rstmid_out", out, 0);
        check("rstmid_valid", out_valid, 0);
        check("rstmid_busy", busy, 0);
        check("rstmid_overrun", overrun, 0);
        #1;
        rst = 1'b0;
        tick();
        exp_q.push_back(8'h81);
        send_range(8'h81, 1'b0, 0, NS);
        check_pop("post_rst_81");

`ifdef SHIFT_DESER_PARITY_EN
        // 01 with parity bit 0 is odd overall: delivered with error flagged.
        exp_q.push_back(8'h01);
        send_range(8'h01, 1'b0, 0, 8);
        check("par_valid_before_pbit", out_valid, 0);
        sin = 1'b0; sin_valid = 1'b1;
        tick();
        sin_valid = 1'b0;
        check("par_err_set", parity_err, 1);
        check_pop("par_bad_word");
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("par_err_cleared", parity_err, 0);
        exp_q.push_back(8'h01);
        send_range(8'h01, 1'b0, 0, NS);
        check("par_err_clean", parity_err, 0);
        check_pop("par_good_word");
`endif

        exp_w = 8'h00;
        if (exp_q.size() != 0) begin
            exp_w = exp_q[0];
            checks++;
            errors++;
            $error("FAIL scoreboard_leftover: %0d words pending, head 0x%0h", exp_q.size(), exp_w);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
